bcd_scan_driver: RTL and testbench
==================================

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 100000, the number of clocks each digit is held before the scan advances.
REQ-002 SHALL provide parameter VAL_W, default 11, the width of the signed two's-complement input value.
REQ-003 SHALL have port clk, input, 1 bit, the rising-edge system clock.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port value, input, VAL_W bits, the signed binary number to display.
REQ-006 SHALL have port load, input, 1 bit, a single-cycle strobe requesting capture of value.
REQ-007 SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-008 SHALL have port en, output, 2 bits, the digit-position select for the downstream segment decoder.
REQ-009 SHALL have port num, output, 4 bits, the digit code for the selected position (0-9 digit, 14 blank, 15 minus).

Function
REQ-010 SHALL implement states IDLE, CONV and COMMIT.
REQ-011 SHALL, in IDLE with load=1, capture sign and magnitude |value| and enter CONV on the next clock.
REQ-012 SHALL hold busy=1 throughout CONV and COMMIT.
REQ-013 SHALL ignore load whenever busy=1, with no queuing.
REQ-014 SHALL run a sequential shift-add-3 conversion in CONV, one magnitude bit per clock, for VAL_W cycles.
REQ-015 SHALL, in COMMIT, update the display registers (units, tens, hundreds, neg, ovf) atomically and return to IDLE.
REQ-016 SHALL make the new display visible exactly VAL_W+1 clocks after the load-accepting edge, with busy falling on that same edge.
REQ-017 SHALL hold the previous display unchanged until COMMIT.
REQ-018 SHALL set ovf=1 when |value|>999, including the most-negative value (-1024).
REQ-019 SHALL, when ovf=1, force num=15 at all four positions.
REQ-020 SHALL run a refresh counter 0..REFRESH_DIV-1; on the wrap to 0, en increments modulo 4 (11->00).
REQ-021 SHALL drive num combinationally from en and the display registers: en=00 units, 01 tens, 10 hundreds, 11 sign (15 if neg, else 14).
REQ-022 SHALL set neg=0 for a value of zero, so no "-0" is ever shown.
REQ-023 SHALL let scanning run continuously and independently of busy.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, set state IDLE, busy=0, en=00, refresh counter 0, all digits 0, neg=0, ovf=0; num therefore reads 0.
REQ-025 SHALL abort any conversion in progress when rst is asserted, with no commit.
REQ-026 SHALL give rst priority over a simultaneous load.

Configuration
REQ-027 SHALL, with macro LEADING_ZERO_BLANK_EN defined, output 14 for the hundreds position when hundreds=0, and for the tens position when both hundreds and tens are 0; the units position is never blanked.
REQ-028 SHALL, without LEADING_ZERO_BLANK_EN, output all digit positions numerically, including zeros.

Structure
REQ-029 SHALL place the state encoding and the constants CODE_BLANK=14 and CODE_MINUS=15 in the shared package seg_pkg.
REQ-030 SHALL implement the conversion datapath in one sub-module, bin2bcd_seq (start, magnitude in; done, three BCD nibbles out); the FSM, scan counter and output mux remain in the top level.

Verification
REQ-031 SHALL cover: load value=123 -> busy high for 12 clocks, then en 00/01/10/11 yields num 3/2/1/14.
REQ-032 SHALL cover: load -45 -> num 5/4/14/15 with LEADING_ZERO_BLANK_EN, and 5/4/0/15 without it.
REQ-033 SHALL cover: load 1000, then load -1024 -> num 15 at all positions in both cases; a following load of 0 -> 0/14/14/14 (blank enabled).
REQ-034 SHALL cover: load 7, then a second load of 9 issued 3 clocks later -> the second load is ignored and the display shows 7.
REQ-035 SHALL cover: REFRESH_DIV=4 -> en changes every 4 clocks in the order 00,01,10,11,00, with num tracking en in the same cycle.
REQ-036 SHALL cover: rst asserted 5 clocks into a conversion of 500 -> next cycle busy=0, en=00, num=0, and 500 is never displayed.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the BCD scan display driver.
package seg_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned MAX_SHOWN = 999;

  localparam logic [DIGIT_W-1:0] CODE_BLANK = 4'd14;
  localparam logic [DIGIT_W-1:0] CODE_MINUS = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Atomically committed display contents.
  typedef struct packed {
    logic               ovf;
    logic               neg;
    logic [DIGIT_W-1:0] hund;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;
  } disp_t;

  function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one magnitude bit per clock.
// done is high during the clock in which the final shift is performed.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned VAL_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VAL_W-1:0]   magnitude,
  output logic               done,
  output logic [DIGIT_W-1:0] bcd_units,
  output logic [DIGIT_W-1:0] bcd_tens,
  output logic [DIGIT_W-1:0] bcd_hund
);

  localparam int unsigned CNT_W = $clog2(VAL_W + 1);
  localparam int unsigned BCD_W = 3 * DIGIT_W;

  logic [VAL_W-1:0] sr_q, sr_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  always_comb begin
    sr_d   = sr_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    adj_c  = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    if (start) begin
      sr_d  = magnitude;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d  = BCD_W'({adj_c, sr_q[VAL_W-1]});
      sr_d   = VAL_W'({sr_q, 1'b0});
      cnt_d  = cnt_q + CNT_W'(1);
      // Flag one clock ahead so the controller leaves CONV on the last shift.
      done_d = (cnt_q == CNT_W'(VAL_W - 2));
      if (cnt_q == CNT_W'(VAL_W - 1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign bcd_units = bcd_q[3:0];
  assign bcd_tens  = bcd_q[7:4];
  assign bcd_hund  = bcd_q[11:8];

endmodule

// File: rtl/bcd_scan_driver.sv
// Signed value to 4-position multiplexed digit-code driver with scan refresh.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module bcd_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned VAL_W       = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VAL_W-1:0]   value,
  input  logic               load,
  output logic               busy,
  output logic [1:0]         en,
  output logic [DIGIT_W-1:0] num
);

  localparam int unsigned RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             neg_cap_q, neg_cap_d;
  logic             ovf_cap_q, ovf_cap_d;
  disp_t            disp_q, disp_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [1:0]       en_q, en_d;
  logic [VAL_W-1:0] mag_c;
  logic             start_c;
  logic             conv_done;
  logic [DIGIT_W-1:0] conv_units, conv_tens, conv_hund;

  assign mag_c = value[VAL_W-1] ? (~value) + VAL_W'(1) : value;

  bin2bcd_seq #(.VAL_W(VAL_W)) u_conv (
    .clk       (clk),
    .rst       (rst),
    .start     (start_c),
    .magnitude (mag_c),
    .done      (conv_done),
    .bcd_units (conv_units),
    .bcd_tens  (conv_tens),
    .bcd_hund  (conv_hund)
  );

  // Conversion control; the display only changes in COMMIT.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    neg_cap_d = neg_cap_q;
    ovf_cap_d = ovf_cap_q;
    disp_d    = disp_q;
    start_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          start_c   = 1'b1;
          neg_cap_d = value[VAL_W-1] && (mag_c != '0);
          ovf_cap_d = 32'(mag_c) > 32'(MAX_SHOWN);
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        if (conv_done) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d.ovf   = ovf_cap_q;
        disp_d.neg   = neg_cap_q;
        disp_d.hund  = conv_hund;
        disp_d.tens  = conv_tens;
        disp_d.units = conv_units;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Free-running scan, independent of conversions.
  always_comb begin
    rc_d = rc_q + RC_W'(1);
    en_d = en_q;
    if (rc_q == RC_W'(REFRESH_DIV - 1)) begin
      rc_d = '0;
      en_d = en_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      neg_cap_q <= 1'b0;
      ovf_cap_q <= 1'b0;
      disp_q    <= '0;
      rc_q      <= '0;
      en_q      <= 2'd0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      neg_cap_q <= neg_cap_d;
      ovf_cap_q <= ovf_cap_d;
      disp_q    <= disp_d;
      rc_q      <= rc_d;
      en_q      <= en_d;
    end
  end

  always_comb begin
    num = disp_q.units;
    if (disp_q.ovf) begin
      num = CODE_MINUS;
    end else begin
      case (en_q)
        2'd0: num = disp_q.units;
`ifdef LEADING_ZERO_BLANK_EN
        2'd1: num = (disp_q.hund == '0 && disp_q.tens == '0) ? CODE_BLANK : disp_q.tens;
        2'd2: num = (disp_q.hund == '0) ? CODE_BLANK : disp_q.hund;
`else
        2'd1: num = disp_q.tens;
        2'd2: num = disp_q.hund;
`endif
        default: num = disp_q.neg ? CODE_MINUS : CODE_BLANK;
      endcase
    end
  end

  assign busy = busy_q;
  assign en   = en_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Scoreboard bench for bcd_scan_driver: loaded values are queued and checked
// against a decimal reference model once the DUT commits them.
module tb_bcd_scan_driver;

  localparam int unsigned VAL_W     = 11;
  localparam int unsigned RDIV      = 4;
  localparam int          CONV_CLKS = VAL_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [VAL_W-1:0] value;
  logic             busy;
  logic [1:0]       en;
  logic [3:0]       num;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int prev_v   = 0;
  int cyc      = 0;

  bcd_scan_driver #(.REFRESH_DIV(RDIV), .VAL_W(VAL_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .en    (en),
    .num   (num)
  );

  always #5 clk = ~clk;

  // Clocks since the last reset edge; the expected scan position follows from it.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_en();
    return (cyc / RDIV) % 4;
  endfunction

  function automatic int exp_code(input int v, input int pos);
    int m, h, t, u;
    bit blank;
`ifdef LEADING_ZERO_BLANK_EN
    blank = 1'b1;
`else
    blank = 1'b0;
`endif
    m = (v < 0) ? -v : v;
    if (m > 999) return 15;
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    case (pos)
      0:       return u;
      1:       return (blank && h == 0 && t == 0) ? 14 : t;
      2:       return (blank && h == 0) ? 14 : h;
      default: return (v < 0) ? 15 : 14;
    endcase
  endfunction

  task automatic check_display(input string tag, input int v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_eq({tag, "_en"}, int'(en), exp_en());
      check_eq({tag, "_num"}, int'(num), exp_code(v, exp_en()));
      @(negedge clk);
    end
  endtask

  task automatic load_val(input int v);
    bit was_busy;
    @(negedge clk);
    value    = VAL_W'(v);
    load     = 1'b1;
    was_busy = busy;
    @(negedge clk);
    load = 1'b0;
    if (!was_busy) exp_q.push_back(v);
  endtask

  // Old display must hold while busy; then the queued value must appear.
  task automatic finish_conv(input int exp_len);
    int n = 0;
    int v;
    while (busy === 1'b1 && n < 200) begin
      check_eq("hold_num", int'(num), exp_code(prev_v, exp_en()));
      n++;
      @(negedge clk);
    end
    check_eq("busy_len", n, exp_len);
    check_eq("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      check_display("disp", v, 4 * RDIV);
      prev_v = v;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[5] = '{123, -45, 1000, -1024, 0};
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_en", int'(en), 0);
    check_eq("rst_num", int'(num), 0);
    check_display("idle", 0, 5 * RDIV);

    foreach (vals[i]) begin
      load_val(vals[i]);
      finish_conv(CONV_CLKS);
    end

    // A load issued while busy is dropped.
    load_val(7);
    @(negedge clk);
    load_val(9);
    finish_conv(CONV_CLKS - 3);

    for (int i = 0; i < 4; i++) begin
      load_val(int'($urandom_range(0, 2047)) - 1024);
      finish_conv(CONV_CLKS);
    end

    // Reset in mid-conversion aborts without commit.
    load_val(500);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    prev_v = 0;
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_en", int'(en), 0);
    check_eq("abort_num", int'(num), 0);
    for (int i = 0; i < 4 * RDIV; i++) begin
      check_eq("abort_idle", int'(busy), 0);
      check_eq("abort_disp", int'(num), exp_code(0, exp_en()));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
